// File: rtl/midori_pkg.sv
`default_nettype none
// ============================================================================
// Module   : midori_pkg
// Brief    : Midori64 constants, FSM state type and round-constant helper.
// Revision : 1.0
// ============================================================================
package midori_pkg;

  localparam int SBOX_LAT_DEF = 4;
  localparam int NROUNDS      = 15;
  localparam int RND_W        = 4;

  // Entry r, bit 15 belongs to cell 0.
  localparam logic [0:NROUNDS-1][15:0] BETA = {
    16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
    16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
    16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90
  };

  localparam logic [0:15][3:0] PERM = {
    4'd0,  4'd10, 4'd5,  4'd15, 4'd14, 4'd4,  4'd11, 4'd1,
    4'd9,  4'd3,  4'd12, 4'd6,  4'd7,  4'd13, 4'd2,  4'd8
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Spread BETA[rnd] onto the LSB of each 4-bit cell; zero for rnd >= NROUNDS.
  function automatic logic [63:0] round_const(input logic [RND_W-1:0] rnd);
    logic [63:0] m;
    m = '0;
    for (int r = 0; r < NROUNDS; r++) begin
      if (rnd == RND_W'(r)) begin
        for (int j = 0; j < 16; j++) begin
          m[60-4*j] = BETA[r][15-j];
        end
      end
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/midori_lin_layer.sv
`default_nettype none
// ============================================================================
// Module   : midori_lin_layer
// Brief    : Midori64 ShuffleCell followed by MixColumn on a single share.
// Revision : 1.0
// ============================================================================
module midori_lin_layer
  import midori_pkg::*;
(
  input  logic [63:0] d_i,
  output logic [63:0] q_o
);

  logic [0:15][3:0] w_in_c;
  logic [0:15][3:0] w_sh_c;
  logic [0:15][3:0] w_mc_c;

  assign w_in_c = d_i;

  for (genvar i = 0; i < 16; i++) begin : g_shuffle
    assign w_sh_c[i] = w_in_c[PERM[i]];
  end

  // Each output cell is the XOR of the other three cells in its column.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_mc_c[4*c+r] = w_sh_c[4*c] ^ w_sh_c[4*c+1] ^ w_sh_c[4*c+2]
                           ^ w_sh_c[4*c+3] ^ w_sh_c[4*c+r];
    end
  end

  assign q_o = w_mc_c;

endmodule
`default_nettype wire

// File: rtl/midori_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : midori_round_ctrl
// Brief    : Three-share Midori64 round controller driving an external
//            masked Sbox layer; linear layer and key addition per share.
// Revision : 1.0
// ============================================================================
module midori_round_ctrl
  import midori_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [63:0]   pt0,
  input  logic [63:0]   pt1,
  input  logic [63:0]   pt2,
  input  logic [127:0]  key0,
  input  logic [127:0]  key1,
  input  logic [127:0]  key2,
  output logic [63:0]   sb_in0,
  output logic [63:0]   sb_in1,
  output logic [63:0]   sb_in2,
  input  logic [63:0]   sb_out0,
  input  logic [63:0]   sb_out1,
  input  logic [63:0]   sb_out2,
  output logic          busy,
  output logic          done,
  output logic [63:0]   ct0,
  output logic [63:0]   ct1,
  output logic [63:0]   ct2
);

  localparam int                 C_CNT_W    = (SBOX_LAT < 1) ? 1 : $clog2(SBOX_LAT + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(SBOX_LAT);
  localparam logic [RND_W-1:0]   C_RND_LAST = RND_W'(NROUNDS);

  state_e               fsm_q, fsm_d;
  logic [2:0][63:0]     state_q, state_d;
  logic [RND_W-1:0]     rnd_q, rnd_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;

  logic [2:0][63:0]     w_pt;
  logic [2:0][127:0]    w_key;
  logic [2:0][63:0]     w_sbo;
  logic [2:0][63:0]     w_lin;
  logic [2:0][63:0]     w_wk;
  logic [2:0][63:0]     w_rk;
  logic [63:0]          w_rc;

  assign w_pt  = {pt2, pt1, pt0};
  assign w_key = {key2, key1, key0};
  assign w_sbo = {sb_out2, sb_out1, sb_out0};
  assign w_rc  = round_const(rnd_q);

  // Every share is processed on its own; only share 0 carries the round constant.
  for (genvar s = 0; s < 3; s++) begin : g_share
    assign w_wk[s] = w_key[s][127:64] ^ w_key[s][63:0];
    assign w_rk[s] = (rnd_q[0] ? w_key[s][63:0] : w_key[s][127:64])
                   ^ ((s == 0) ? w_rc : 64'd0);

    midori_lin_layer u_lin (
      .d_i (w_sbo[s]),
      .q_o (w_lin[s])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d   = SUB;
          state_d = w_pt ^ w_wk;
          rnd_d   = '0;
          cnt_d   = '0;
        end
      end
      SUB: begin
        if (cnt_q == C_CNT_MAX) begin
          cnt_d = '0;
          if (rnd_q == C_RND_LAST) begin
            state_d = w_sbo ^ w_wk;
            fsm_d   = DONE;
          end else begin
            state_d = w_lin ^ w_rk;
            rnd_d   = rnd_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb_in0 = state_q[0];
  assign sb_in1 = state_q[1];
  assign sb_in2 = state_q[2];
  assign ct0    = state_q[0];
  assign ct1    = state_q[1];
  assign ct2    = state_q[2];
  assign busy   = (fsm_q != IDLE);
  assign done   = (fsm_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_midori_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_midori_round_ctrl
// Brief    : Self-checking bench: randomized share splits, a pipelined masked
//            Sbox stand-in and a plain Midori64 reference model.
// Revision : 1.0
// ============================================================================
module tb_midori_round_ctrl;

  localparam logic [3:0]  SB_T   [0:15] = '{4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
                                            4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
  localparam int          P_T    [0:15] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
  localparam logic [15:0] BETA_T [0:14] = '{16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
                                            16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
                                            16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90};

  logic clk, rst;
  int   cyc;
  int   checks, errors;

  logic               start_a, start_b;
  logic [2:0][63:0]   pt_a, pt_b;
  logic [2:0][127:0]  key_a, key_b;
  logic [63:0]        sbi_a0, sbi_a1, sbi_a2, sbi_b0, sbi_b1, sbi_b2;
  logic [63:0]        ct_a0, ct_a1, ct_a2, ct_b0, ct_b1, ct_b2;
  logic               busy_a, done_a, busy_b, done_b;
  logic [2:0][63:0]   pipe_a [0:3];
  logic [2:0][63:0]   pipe_b [0:1];

  midori_round_ctrl #(.SBOX_LAT(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .pt0(pt_a[0]), .pt1(pt_a[1]), .pt2(pt_a[2]),
    .key0(key_a[0]), .key1(key_a[1]), .key2(key_a[2]),
    .sb_in0(sbi_a0), .sb_in1(sbi_a1), .sb_in2(sbi_a2),
    .sb_out0(pipe_a[3][0]), .sb_out1(pipe_a[3][1]), .sb_out2(pipe_a[3][2]),
    .busy(busy_a), .done(done_a),
    .ct0(ct_a0), .ct1(ct_a1), .ct2(ct_a2)
  );

  midori_round_ctrl #(.SBOX_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .pt0(pt_b[0]), .pt1(pt_b[1]), .pt2(pt_b[2]),
    .key0(key_b[0]), .key1(key_b[1]), .key2(key_b[2]),
    .sb_in0(sbi_b0), .sb_in1(sbi_b1), .sb_in2(sbi_b2),
    .sb_out0(pipe_b[1][0]), .sb_out1(pipe_b[1][1]), .sb_out2(pipe_b[1][2]),
    .busy(busy_b), .done(done_b),
    .ct0(ct_b0), .ct1(ct_b1), .ct2(ct_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[63-4*i -: 4] = SB_T[x[63-4*i -: 4]];
    return y;
  endfunction

  // Fresh random re-sharing of the Sbox result every cycle.
  function automatic logic [2:0][63:0] reshare(input logic [63:0] y);
    logic [2:0][63:0] r;
    r[1] = rnd64();
    r[2] = rnd64();
    r[0] = y ^ r[1] ^ r[2];
    return r;
  endfunction

  always @(posedge clk) begin
    pipe_a[0] <= reshare(sbox_layer(sbi_a0 ^ sbi_a1 ^ sbi_a2));
    for (int k = 1; k < 4; k++) pipe_a[k] <= pipe_a[k-1];
    pipe_b[0] <= reshare(sbox_layer(sbi_b0 ^ sbi_b1 ^ sbi_b2));
    pipe_b[1] <= pipe_b[0];
  end

  // Unmasked Midori64 encryption, cell by cell.
  function automatic logic [63:0] midori64(input logic [63:0] p, input logic [127:0] k);
    logic [3:0]  c [0:15];
    logic [3:0]  t [0:15];
    logic [63:0] x, wk, rk;
    wk = k[127:64] ^ k[63:0];
    x  = p ^ wk;
    for (int r = 0; r < 15; r++) begin
      x = sbox_layer(x);
      for (int i = 0; i < 16; i++) c[i] = x[63-4*P_T[i] -: 4];
      for (int i = 0; i < 16; i++)
        t[i] = c[(i/4)*4] ^ c[(i/4)*4+1] ^ c[(i/4)*4+2] ^ c[(i/4)*4+3] ^ c[i];
      rk = (r % 2 == 1) ? k[63:0] : k[127:64];
      for (int i = 0; i < 16; i++)
        x[63-4*i -: 4] = t[i] ^ rk[63-4*i -: 4] ^ {3'b000, BETA_T[r][15-i]};
    end
    return sbox_layer(x) ^ wk;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic [63:0] ctx(input bit sel);
    return sel ? (ct_b0 ^ ct_b1 ^ ct_b2) : (ct_a0 ^ ct_a1 ^ ct_a2);
  endfunction

  function automatic logic [63:0] sbx(input bit sel);
    return sel ? (sbi_b0 ^ sbi_b1 ^ sbi_b2) : (sbi_a0 ^ sbi_a1 ^ sbi_a2);
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic load(input bit sel, input logic [63:0] p, input logic [127:0] k);
    logic [63:0]  r0, r1;
    logic [127:0] q0, q1;
    r0 = rnd64(); r1 = rnd64();
    q0 = {rnd64(), rnd64()}; q1 = {rnd64(), rnd64()};
    if (sel) begin
      pt_b  = {p ^ r0 ^ r1, r1, r0};
      key_b = {k ^ q0 ^ q1, q1, q0};
    end else begin
      pt_a  = {p ^ r0 ^ r1, r1, r0};
      key_a = {k ^ q0 ^ q1, q1, q0};
    end
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic enc(input bit sel, input logic [63:0] p, input logic [127:0] k, input bit spur,
                     output int c0, output int lat, output logic [63:0] ct);
    load(sel, p, k);
    set_start(sel, 1'b1);
    c0 = cyc;
    @(negedge clk);
    set_start(sel, 1'b0);
    chk_eq("sbin_load", sbx(sel), p ^ k[127:64] ^ k[63:0]);
    while (!get_done(sel) && (cyc - c0) < 400) begin
      @(negedge clk);
      set_start(sel, spur && ((cyc - c0) == 10 || (cyc - c0) == 40));
    end
    lat = get_done(sel) ? (cyc - c0) : -1;
    ct  = ctx(sel);
  endtask

  task automatic hold_chk(input bit sel, input logic [63:0] ct, input int n);
    int pulses, bz, bad;
    pulses = 0; bz = 0; bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (get_done(sel)) pulses++;
      if (get_busy(sel)) bz++;
      if (ctx(sel) !== ct) bad++;
    end
    chk_eq("hold_done", 64'(pulses), 64'd0);
    chk_eq("hold_busy", 64'(bz), 64'd0);
    chk_eq("hold_ct", 64'(bad), 64'd0);
  endtask

  int          c0, c1, lat, lat2;
  logic [63:0] ct, ct2, p;
  logic [127:0] k;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    pt_a = '0; pt_b = '0; key_a = '0; key_b = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", 64'(busy_a), 64'd0);
    chk_eq("rst_done", 64'(done_a), 64'd0);
    chk_eq("rst_ct", ct_a0 | ct_a1 | ct_a2, 64'd0);
    chk_eq("rst_sbin", sbi_a0 | sbi_a1 | sbi_a2, 64'd0);
    // start held high during reset must not be taken
    start_a = 1'b1;
    @(negedge clk);
    chk_eq("rst_prio_busy", 64'(busy_a), 64'd0);
    start_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    enc(1'b0, 64'd0, 128'd0, 1'b0, c0, lat, ct);
    chk_eq("v0_lat", 64'(lat), 64'd81);
    chk_eq("v0_ct", ct, 64'h3c9cceda2bbd449a);
    chk_eq("v0_ref", ct, midori64(64'd0, 128'd0));
    hold_chk(1'b0, ct, 8);

    p = 64'h42c20fd3b586879e;
    k = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
    enc(1'b0, p, k, 1'b0, c0, lat, ct);
    chk_eq("v1_lat", 64'(lat), 64'd81);
    chk_eq("v1_ct", ct, 64'h66bcdc6270d901cd);
    chk_eq("v1_ref", ct, midori64(p, k));
    hold_chk(1'b0, ct, 4);

    p = rnd64(); k = {rnd64(), rnd64()};
    enc(1'b0, p, k, 1'b1, c0, lat, ct);
    chk_eq("spur_lat", 64'(lat), 64'd81);
    chk_eq("spur_ct", ct, midori64(p, k));
    hold_chk(1'b0, ct, 100);

    load(1'b0, rnd64(), {rnd64(), rnd64()});
    start_a = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_a = 1'b0;
    while ((cyc - c0) < 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_busy", 64'(busy_a), 64'd0);
    chk_eq("abort_done", 64'(done_a), 64'd0);
    chk_eq("abort_ct", ct_a0 | ct_a1 | ct_a2, 64'd0);
    rst = 1'b0;
    hold_chk(1'b0, 64'd0, 100);
    p = rnd64(); k = {rnd64(), rnd64()};
    enc(1'b0, p, k, 1'b0, c0, lat, ct);
    chk_eq("after_abort_lat", 64'(lat), 64'd81);
    chk_eq("after_abort_ct", ct, midori64(p, k));

    @(negedge clk);
    p = rnd64(); k = {rnd64(), rnd64()};
    enc(1'b0, p, k, 1'b0, c0, lat, ct);
    chk_eq("b2b_first_ct", ct, midori64(p, k));
    @(negedge clk);
    chk_eq("b2b_idle_busy", 64'(busy_a), 64'd0);
    p = rnd64(); k = {rnd64(), rnd64()};
    enc(1'b0, p, k, 1'b0, c1, lat2, ct2);
    chk_eq("b2b_gap", 64'(c1 - c0), 64'd82);
    chk_eq("b2b_total", 64'(c1 - c0 + lat2), 64'd163);
    chk_eq("b2b_second_ct", ct2, midori64(p, k));
    hold_chk(1'b0, ct2, 3);

    for (int n = 0; n < 4; n++) begin
      p = rnd64(); k = {rnd64(), rnd64()};
      enc(1'b0, p, k, 1'b0, c0, lat, ct);
      chk_eq("rand_lat", 64'(lat), 64'd81);
      chk_eq("rand_ct", ct, midori64(p, k));
      hold_chk(1'b0, ct, 2);
    end

    enc(1'b1, 64'd0, 128'd0, 1'b0, c0, lat, ct);
    chk_eq("lat2_lat", 64'(lat), 64'd49);
    chk_eq("lat2_ct", ct, 64'h3c9cceda2bbd449a);
    hold_chk(1'b1, ct, 4);
    p = rnd64(); k = {rnd64(), rnd64()};
    enc(1'b1, p, k, 1'b0, c0, lat, ct);
    chk_eq("lat2_rand_lat", 64'(lat), 64'd49);
    chk_eq("lat2_rand_ct", ct, midori64(p, k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
